// File: rtl/clm_din_packer.sv
// clm_din_packer: packs plaintext, p selector and LFSR-driven random lanes into a 512-bit CLM frame,
// hands it to the framework and captures the returned ciphertext with a bounded wait.
module clm_din_packer #(
    parameter int D       = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         EN,
    input  logic [127:0] pt_in,
    input  logic         pt_vld,
    output logic         pt_rdy,
    input  logic [4:0]   p_cfg,
    input  logic [31:0]  seed_in,
    input  logic         seed_ld,
    output logic [511:0] Din,
    output logic         Drdy,
    input  logic         Dvld,
    input  logic [127:0] Dout,
    output logic [127:0] ct_out,
    output logic         ct_vld,
    output logic         BSY,
    output logic         err
);
    typedef enum logic [1:0] {IDLE, FILL, ISSUE, WAIT} state_t;
    localparam logic [15:0] LMASK = 16'hFFFF << (16 - D);
    localparam logic [9:0]  TLAST = 10'(TIMEOUT - 1);
    state_t         state_q, state_d;
    logic [31:0]    lfsr_q, lfsr_d, lfsr_step;
    logic [4:0]     lane_q, lane_d;
    logic [9:0]     timer_q, timer_d;
    logic [511:0]   din_q, din_d;
    logic [127:0]   ct_q, ct_d;
    logic           ctv_q, ctv_d, err_q, err_d;
    // Galois form of x^32+x^22+x^2+x+1, shifting left, 16 steps per call
    function automatic logic [31:0] step16(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < 16; i++) r = {r[30:0], 1'b0} ^ (r[31] ? 32'h0040_0007 : 32'h0);
        return r;
    endfunction
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        timer_d   = timer_q;
        din_d     = din_q;
        ct_d      = ct_q;
        ctv_d     = 1'b0;
        err_d     = err_q;
        lfsr_step = step16(lfsr_q);
        lfsr_d    = lfsr_q;
        case (state_q)
            IDLE: if (pt_vld) begin
                din_d   = {11'b0, p_cfg, 368'b0, pt_in};
                err_d   = 1'b0;
                lane_d  = 5'd0;
                state_d = FILL;
            end
            FILL: begin
                din_d[9'd495 - {lane_q, 4'b0000} -: 16] = lfsr_step[31:16] & LMASK;
                lfsr_d  = lfsr_step;
                lane_d  = lane_q + 5'd1;
                state_d = (lane_q == 5'd22) ? ISSUE : FILL;
            end
            ISSUE: begin
                timer_d = 10'd0;
                state_d = WAIT;
            end
            WAIT: if (Dvld) begin
                ct_d    = Dout;
                ctv_d   = 1'b1;
                state_d = IDLE;
            end else if (timer_q == TLAST) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                timer_d = timer_q + 10'd1;
            end
            default: state_d = IDLE;
        endcase
        if (seed_ld) lfsr_d = (seed_in == 32'h0) ? 32'h1 : seed_in;
    end
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            lfsr_q  <= 32'h1;
            lane_q  <= 5'd0;
            timer_q <= 10'd0;
            din_q   <= '0;
            ct_q    <= '0;
            ctv_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // ct_vld is a pulse, so it drops rather than holds while disabled
            ctv_q <= EN & ctv_d;
            if (EN) begin
                state_q <= state_d;
                lfsr_q  <= lfsr_d;
                lane_q  <= lane_d;
                timer_q <= timer_d;
                din_q   <= din_d;
                ct_q    <= ct_d;
                err_q   <= err_d;
            end
        end
    end
    assign pt_rdy = (state_q == IDLE);
    assign BSY    = (state_q != IDLE);
    assign Drdy   = EN && (state_q == ISSUE);
    assign Din    = din_q;
    assign ct_out = ct_q;
    assign ct_vld = ctv_q;
    assign err    = err_q;
endmodule

// File: tb/tb_clm_din_packer.sv
// tb_clm_din_packer: table-driven frame/ciphertext vectors plus hand sequences for enable freeze,
// mid-operation reset and ignored handshakes.
module tb_clm_din_packer;
    localparam int TIMEOUT = 1023;
    logic         CLK = 0, RSTn = 0, EN = 1, pt_vld = 0, seed_ld = 0, Dvld = 0;
    logic [127:0] pt_in = '0, Dout = '0;
    logic [4:0]   p_cfg = '0;
    logic [31:0]  seed_in = '0;
    logic         pt_rdy, Drdy, ct_vld, BSY, err;
    logic [511:0] Din;
    logic [127:0] ct_out;
    int checks = 0, failures = 0, drdy_n = 0, ctv_n = 0;
    logic [31:0]  m_lfsr = 32'h1;
    logic [15:0]  last [23];
    logic [15:0]  lanes1 [23];

    clm_din_packer #(.D(8), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RSTn(RSTn), .EN(EN), .pt_in(pt_in), .pt_vld(pt_vld), .pt_rdy(pt_rdy),
        .p_cfg(p_cfg), .seed_in(seed_in), .seed_ld(seed_ld), .Din(Din), .Drdy(Drdy),
        .Dvld(Dvld), .Dout(Dout), .ct_out(ct_out), .ct_vld(ct_vld), .BSY(BSY), .err(err)
    );

    always #5 CLK = ~CLK;
    always @(negedge CLK) begin
        if (Drdy) drdy_n++;
        if (ct_vld) ctv_n++;
    end
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    typedef struct {
        logic         do_seed;
        logic [31:0]  seed;
        logic [127:0] pt;
        logic [4:0]   p;
        int           dly;
        logic [127:0] dout;
        logic [127:0] exp_ct;
        logic         exp_err;
    } vec_t;
    vec_t tv [4];

    task tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] adv(input logic [31:0] s);
        logic [31:0] r = s;
        for (int i = 0; i < 16; i++) r = r[31] ? ((r << 1) ^ 32'h0040_0007) : (r << 1);
        return r;
    endfunction

    task automatic wait_drdy(input int start, input int exp_lat, input string nm);
        int lat = start;
        while (!Drdy && lat < 100) begin
            tick;
            lat++;
        end
        chk(nm, lat, exp_lat);
    endtask

    task automatic check_din(input logic [4:0] p, input logic [127:0] pt);
        int bad = 0;
        logic [7:0] low = 0;
        logic [15:0] e;
        chk("din_top", Din[511:501], 0);
        chk("din_p", Din[500:496], p);
        chk("din_pt", Din[127:0], pt);
        for (int k = 0; k < 23; k++) begin
            m_lfsr = adv(m_lfsr);
            e = m_lfsr[31:16] & 16'hFF00;
            last[k] = Din[495-16*k -: 16];
            low |= last[k][7:0];
            if (last[k] !== e) bad++;
        end
        chk("din_lanes_bad", bad, 0);
        chk("din_lane_low", low, 0);
    endtask

    task automatic load_seed(input logic [31:0] s);
        seed_in = s;
        seed_ld = 1;
        tick;
        seed_ld = 0;
        m_lfsr = (s == 0) ? 32'h1 : s;
    endtask

    task automatic accept(input logic [127:0] pt, input logic [4:0] p);
        chk("pt_rdy_idle", pt_rdy, 1);
        pt_in = pt;
        p_cfg = p;
        pt_vld = 1;
        tick;
        pt_vld = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_din"}, Din, 0);
        chk({tag, "_drdy"}, Drdy, 0);
        chk({tag, "_ct"}, ct_out, 0);
        chk({tag, "_ctvld"}, ct_vld, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_ptrdy"}, pt_rdy, 1);
        chk({tag, "_bsy"}, BSY, 0);
    endtask

    initial begin
        int d0, c0, bad;
        logic [511:0] snap;
        tv[0] = '{1'b1, 32'h1, 128'h00112233_44556677_8899AABB_CCDDEEFF, 5'h13, 3,
                  128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF, 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF, 1'b0};
        tv[1] = '{1'b1, 32'h0, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 5'h1F, 1,
                  128'h11112222_33334444_55556666_77778888, 128'h11112222_33334444_55556666_77778888, 1'b0};
        tv[2] = '{1'b1, 32'hACE12345, 128'hFFFFFFFF_00000000_FFFFFFFF_00000001, 5'h00, -1,
                  128'h0, 128'h11112222_33334444_55556666_77778888, 1'b1};
        tv[3] = '{1'b0, 32'h0, 128'h0BADF00D_CAFEBABE_12345678_9ABCDEF0, 5'h0A, 5,
                  128'hFEEDFACE_0000FFFF_13579BDF_2468ACE0, 128'hFEEDFACE_0000FFFF_13579BDF_2468ACE0, 1'b0};
        #12;
        chk_reset_vals("rst0");
        RSTn = 1;
        tick;
        for (int i = 0; i < 4; i++) begin
            if (tv[i].do_seed) load_seed(tv[i].seed);
            d0 = drdy_n;
            c0 = ctv_n;
            accept(tv[i].pt, tv[i].p);
            chk("err_clr", err, 0);
            chk("bsy_fill", BSY, 1);
            wait_drdy(1, 24, "drdy_latency");
            check_din(tv[i].p, tv[i].pt);
            if (tv[i].do_seed && tv[i].seed == 32'h1) for (int k = 0; k < 23; k++) lanes1[k] = last[k];
            if (tv[i].do_seed && tv[i].seed == 32'h0) begin
                bad = 0;
                for (int k = 0; k < 23; k++) if (last[k] !== lanes1[k]) bad++;
                chk("seed0_eq_seed1", bad, 0);
            end
            tick;
            if (tv[i].dly > 0) begin
                repeat (tv[i].dly - 1) tick;
                Dout = tv[i].dout;
                Dvld = 1;
                tick;
                Dvld = 0;
                chk("ct_vld_pulse", ct_vld, 1);
                chk("pt_rdy_after", pt_rdy, 1);
                tick;
                chk("ct_vld_drop", ct_vld, 0);
            end else begin
                repeat (TIMEOUT - 1) tick;
                chk("to_err_early", err, 0);
                chk("to_bsy_early", BSY, 1);
                tick;
                chk("to_idle", pt_rdy, 1);
            end
            chk("ct_out", ct_out, tv[i].exp_ct);
            chk("err_final", err, tv[i].exp_err);
            chk("drdy_count", drdy_n, d0 + 1);
            chk("ctv_count", ctv_n, c0 + (tv[i].dly > 0 ? 1 : 0));
        end
        // Dvld during FILL and pt_vld during WAIT must be ignored
        c0 = ctv_n;
        accept(128'h55555555_66666666_77777777_88888888, 5'h07);
        Dout = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
        Dvld = 1;
        repeat (3) tick;
        Dvld = 0;
        chk("fill_dvld_ct", ct_out, tv[3].exp_ct);
        chk("fill_dvld_ctv", ctv_n, c0);
        wait_drdy(4, 24, "drdy_latency_b");
        check_din(5'h07, 128'h55555555_66666666_77777777_88888888);
        snap = Din;
        tick;
        pt_in = 128'h99999999_99999999_99999999_99999999;
        pt_vld = 1;
        repeat (2) tick;
        chk("wait_ptrdy", pt_rdy, 0);
        pt_vld = 0;
        chk("wait_din_stable", Din, snap);
        Dout = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
        Dvld = 1;
        tick;
        Dvld = 0;
        chk("b_ct_out", ct_out, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);
        chk("b_ct_vld", ct_vld, 1);
        tick;
        chk("b_not_requeued", BSY, 0);
        // EN low for 5 FILL cycles, then reset during WAIT
        load_seed(32'h1);
        d0 = drdy_n;
        c0 = ctv_n;
        accept(128'h01020304_05060708_090A0B0C_0D0E0F10, 5'h13);
        repeat (4) tick;
        EN = 0;
        repeat (5) tick;
        chk("en_low_drdy", Drdy, 0);
        EN = 1;
        wait_drdy(10, 29, "drdy_latency_en");
        check_din(5'h13, 128'h01020304_05060708_090A0B0C_0D0E0F10);
        repeat (2) tick;
        RSTn = 0;
        Dvld = 1;
        Dout = 128'h1;
        #1;
        chk_reset_vals("rst_wait");
        repeat (2) tick;
        RSTn = 1;
        repeat (3) tick;
        Dvld = 0;
        tick;
        chk("rst_no_ctv", ctv_n, c0);
        chk("rst_one_drdy", drdy_n, d0 + 1);
        chk("rst_ct_out", ct_out, 0);
        chk("rst_idle", pt_rdy, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clm_din_packer.md
CLM_DIN_PACKER -- requirements
Module: clm_din_packer

Interface
REQ-001 Parameter D, default 8, number of live random bits per 16-bit random lane (1..16).
REQ-002 Parameter TIMEOUT, default 1023, maximum WAIT cycles before abort (1..1023).
REQ-003 CLK  in  1  system clock; all state updates on rising edge.
REQ-004 RSTn  in  1  asynchronous, active-low reset.
REQ-005 EN  in  1  enable; when low, all registers hold and Drdy stays 0.
REQ-006 pt_in  in  128  plaintext from host.
REQ-007 pt_vld  in  1  plaintext valid.
REQ-008 pt_rdy  out  1  packer accepts plaintext; equals (state==IDLE).
REQ-009 p_cfg  in  5  p selector, captured with plaintext.
REQ-010 seed_in  in  32  LFSR seed.
REQ-011 seed_ld  in  1  load seed_in into LFSR.
REQ-012 Din  out  512  frame to CLM framework.
REQ-013 Drdy  out  1  one-cycle frame-ready pulse to the framework.
REQ-014 Dvld  in  1  framework result valid.
REQ-015 Dout  in  128  framework ciphertext.
REQ-016 ct_out  out  128  captured ciphertext.
REQ-017 ct_vld  out  1  one-cycle pulse when ct_out updates.
REQ-018 BSY  out  1  high in any state other than IDLE.
REQ-019 err  out  1  sticky timeout flag; cleared by next accepted plaintext.

Function
REQ-020 Din layout: [511:501]=0, [500:496]=p, lane k (k=0..22) at Din[495-16k : 480-16k], [127:0]=plaintext.
REQ-021 Each lane: upper D bits random, lower 16-D bits zero.
REQ-022 LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, advances 16 steps per FILL cycle; lane value = LFSR[31:16] after the advance, masked per REQ-021.
REQ-023 Seed load: on seed_ld (any state), LFSR <= seed_in, or 32'h0000_0001 if seed_in==0; seed_ld has priority over the LFSR step in that cycle.
REQ-024 States: IDLE, FILL, ISSUE, WAIT.
REQ-025 IDLE: on pt_vld&pt_rdy capture pt_in into Din[127:0] and p_cfg into Din[500:496], clear err, lane_ctr<=0, go to FILL.
REQ-026 FILL: each cycle write lane[lane_ctr], increment lane_ctr; after lane 22 go to ISSUE (exactly 23 FILL cycles).
REQ-027 ISSUE: Drdy=1 for exactly one cycle, go to WAIT, timer<=0.
REQ-028 Din SHALL remain stable from ISSUE until the next accepted plaintext.
REQ-029 WAIT: on Dvld, ct_out<=Dout, ct_vld=1 next cycle, go to IDLE; otherwise timer increments.
REQ-030 WAIT timeout: when timer reaches TIMEOUT without Dvld, set err and go to IDLE; ct_out unchanged.
REQ-031 Dvld outside WAIT is ignored; pt_vld outside IDLE is ignored (not queued).
REQ-032 Latency from plaintext acceptance to Drdy: 24 enabled cycles.
REQ-033 EN low mid-operation freezes state, lane_ctr, timer and LFSR; a pending Drdy pulse is delayed, not dropped.

Reset
REQ-034 While RSTn is low: state=IDLE, Din=0, Drdy=0, ct_out=0, ct_vld=0, err=0, LFSR=32'h0000_0001, lane_ctr=0, timer=0; pt_rdy=1, BSY=0.
REQ-035 Reset asserted in any state aborts the operation immediately; no Drdy or ct_vld follows deassertion.

Verification
REQ-036 Reset, seed_ld with 0x1, pt_in=0x00112233..., p_cfg=5'h13 -> Drdy pulse 24 cycles after acceptance; Din[500:496]=0x13, Din[127:0]=pt_in, lanes match the LFSR golden model, lower 8 bits of each lane zero.
REQ-037 Dvld with Dout=0xDEAD...BEEF 3 cycles after Drdy -> ct_out=Dout, single ct_vld pulse, pt_rdy=1 next cycle.
REQ-038 seed_ld with seed_in=0 -> lane sequence identical to seed 0x1 case.
REQ-039 No Dvld -> err=1 and IDLE after TIMEOUT WAIT cycles; next plaintext clears err.
REQ-040 EN low for 5 cycles during FILL and RSTn pulse during WAIT -> Drdy delayed by 5 cycles, exactly one Drdy; reset yields REQ-034 values, no ct_vld.
REQ-041 Dvld during FILL and pt_vld during WAIT -> both ignored; ct_out and Din[127:0] unchanged.
